wb_regfile: RTL and testbench

//   Write-back end of the MEM/WB pipeline interface.
//   - Consumes the WB-stage control/data fields and selects write data (load data vs ALU result).
//   - Commits that data into a 32-entry architectural register file.
//   - Provides two ID-stage read ports with optional same-cycle write->read bypass.
//   - Exposes the selected write-back value for EX forwarding, plus a retired-write counter.

---
 rtl/wb_regfile.sv | 78 +++++++
 tb/tb_wb_regfile.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage register file: selects load/ALU data, commits to a 32-entry array,
// serves two combinational ID read ports. Optional WB->ID bypass under `REGFILE_BYPASS_EN.
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MemtoReg_WB,
   input  logic              RegWrite_WB,
   input  logic [DATA_W-1:0] dmReadData_WB,
   input  logic [DATA_W-1:0] ALUResult_WB,
   input  logic [ADDR_W-1:0] Dst_WB,
   input  logic [ADDR_W-1:0] ReadReg1_ID,
   input  logic [ADDR_W-1:0] ReadReg2_ID,
   output logic [DATA_W-1:0] ReadData1_ID,
   output logic [DATA_W-1:0] ReadData2_ID,
   output logic [DATA_W-1:0] WriteData_WB,
   output logic [CNT_W-1:0]  CommitCount
);

   localparam int NREGS = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [0:NREGS-1];
   logic [CNT_W-1:0]  commit_q;
   logic [CNT_W-1:0]  commit_d;
   logic              wr_qual;

   assign WriteData_WB = MemtoReg_WB ? dmReadData_WB : ALUResult_WB;
   assign wr_qual      = rst_n & RegWrite_WB & (Dst_WB != '0);

   // Counter saturates at all-ones rather than wrapping
   always_comb begin
      commit_d = commit_q;
      if (wr_qual && (commit_q != '1)) begin
         commit_d = commit_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         commit_q <= '0;
      end else begin
         if (wr_qual) begin
            regs_q[Dst_WB] <= WriteData_WB;
         end
         commit_q <= commit_d;
      end
   end

   always_comb begin
      ReadData1_ID = regs_q[ReadReg1_ID];
      ReadData2_ID = regs_q[ReadReg2_ID];
`ifdef REGFILE_BYPASS_EN
      if (wr_qual && (ReadReg1_ID == Dst_WB)) begin
         ReadData1_ID = WriteData_WB;
      end
      if (wr_qual && (ReadReg2_ID == Dst_WB)) begin
         ReadData2_ID = WriteData_WB;
      end
`else
      // No bypass: ports show the array value until the commit edge
`endif
      if (!rst_n || (ReadReg1_ID == '0)) begin
         ReadData1_ID = '0;
      end
      if (!rst_n || (ReadReg2_ID == '0)) begin
         ReadData2_ID = '0;
      end
   end

   assign CommitCount = commit_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile (CNT_W=4 so counter saturation is reachable).
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemtoReg_WB;
   logic        RegWrite_WB;
   logic [31:0] dmReadData_WB;
   logic [31:0] ALUResult_WB;
   logic [4:0]  Dst_WB;
   logic [4:0]  ReadReg1_ID;
   logic [4:0]  ReadReg2_ID;
   logic [31:0] ReadData1_ID;
   logic [31:0] ReadData2_ID;
   logic [31:0] WriteData_WB;
   logic [3:0]  CommitCount;

   int checks = 0;
   int failures = 0;

   wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .MemtoReg_WB(MemtoReg_WB), .RegWrite_WB(RegWrite_WB),
      .dmReadData_WB(dmReadData_WB), .ALUResult_WB(ALUResult_WB), .Dst_WB(Dst_WB),
      .ReadReg1_ID(ReadReg1_ID), .ReadReg2_ID(ReadReg2_ID),
      .ReadData1_ID(ReadData1_ID), .ReadData2_ID(ReadData2_ID),
      .WriteData_WB(WriteData_WB), .CommitCount(CommitCount)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; RegWrite_WB = 1'b1; MemtoReg_WB = 1'b0;
      ALUResult_WB = 32'h0000A5A5; dmReadData_WB = 32'h0; Dst_WB = 5'd5;
      ReadReg1_ID = 5'd5; ReadReg2_ID = 5'd5;
      #1;
      checks++;
      if (ReadData1_ID !== 32'h0) begin
         failures++; $display("FAIL reset_rd1_pre got=%h exp=%h", ReadData1_ID, 32'h0);
      end
      tick(); tick();
      checks++;
      if (ReadData2_ID !== 32'h0) begin
         failures++; $display("FAIL reset_rd2 got=%h exp=%h", ReadData2_ID, 32'h0);
      end
      checks++;
      if (CommitCount !== 4'd0) begin
         failures++; $display("FAIL reset_cnt got=%0d exp=%0d", CommitCount, 0);
      end
      checks++;
      if (WriteData_WB !== 32'h0000A5A5) begin
         failures++; $display("FAIL reset_wdata got=%h exp=%h", WriteData_WB, 32'h0000A5A5);
      end
      rst_n = 1'b1; RegWrite_WB = 1'b0;
      #1;
      checks++;
      if (ReadData1_ID !== 32'h0) begin
         failures++; $display("FAIL reset_reg5 got=%h exp=%h", ReadData1_ID, 32'h0);
      end
   endtask

   task automatic test_alu_write();
      RegWrite_WB = 1'b1; MemtoReg_WB = 1'b0; ALUResult_WB = 32'h1234ABCD;
      dmReadData_WB = 32'h00000BAD; Dst_WB = 5'd8;
      #1;
      checks++;
      if (WriteData_WB !== 32'h1234ABCD) begin
         failures++; $display("FAIL alu_wdata got=%h exp=%h", WriteData_WB, 32'h1234ABCD);
      end
      tick();
      RegWrite_WB = 1'b0; ReadReg1_ID = 5'd8;
      #1;
      checks++;
      if (ReadData1_ID !== 32'h1234ABCD) begin
         failures++; $display("FAIL alu_read got=%h exp=%h", ReadData1_ID, 32'h1234ABCD);
      end
      checks++;
      if (CommitCount !== 4'd1) begin
         failures++; $display("FAIL alu_cnt got=%0d exp=%0d", CommitCount, 1);
      end
   endtask

   task automatic test_load_select();
      RegWrite_WB = 1'b1; MemtoReg_WB = 1'b1; dmReadData_WB = 32'hDEADBEEF;
      ALUResult_WB = 32'h1; Dst_WB = 5'd9;
      #1;
      checks++;
      if (WriteData_WB !== 32'hDEADBEEF) begin
         failures++; $display("FAIL load_wdata got=%h exp=%h", WriteData_WB, 32'hDEADBEEF);
      end
      tick();
      RegWrite_WB = 1'b0; ReadReg2_ID = 5'd9;
      #1;
      checks++;
      if (ReadData2_ID !== 32'hDEADBEEF) begin
         failures++; $display("FAIL load_read got=%h exp=%h", ReadData2_ID, 32'hDEADBEEF);
      end
      checks++;
      if (CommitCount !== 4'd2) begin
         failures++; $display("FAIL load_cnt got=%0d exp=%0d", CommitCount, 2);
      end
   endtask

   task automatic test_zero_guard();
      RegWrite_WB = 1'b1; MemtoReg_WB = 1'b0; ALUResult_WB = 32'hFFFFFFFF;
      Dst_WB = 5'd0; ReadReg1_ID = 5'd0;
      #1;
      checks++;
      if (ReadData1_ID !== 32'h0) begin
         failures++; $display("FAIL zero_same got=%h exp=%h", ReadData1_ID, 32'h0);
      end
      tick();
      RegWrite_WB = 1'b0;
      #1;
      checks++;
      if (ReadData1_ID !== 32'h0) begin
         failures++; $display("FAIL zero_after got=%h exp=%h", ReadData1_ID, 32'h0);
      end
      checks++;
      if (CommitCount !== 4'd2) begin
         failures++; $display("FAIL zero_cnt got=%0d exp=%0d", CommitCount, 2);
      end
   endtask

   task automatic test_hazard();
      logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
      exp_same = 32'h55;
`else
      exp_same = 32'h11;
`endif
      RegWrite_WB = 1'b1; MemtoReg_WB = 1'b0; ALUResult_WB = 32'h11; Dst_WB = 5'd3;
      tick();
      ALUResult_WB = 32'h55; ReadReg1_ID = 5'd3; ReadReg2_ID = 5'd3;
      #1;
      checks++;
      if (ReadData1_ID !== exp_same) begin
         failures++; $display("FAIL hazard_rd1 got=%h exp=%h", ReadData1_ID, exp_same);
      end
      checks++;
      if (ReadData2_ID !== exp_same) begin
         failures++; $display("FAIL hazard_rd2 got=%h exp=%h", ReadData2_ID, exp_same);
      end
      tick();
      RegWrite_WB = 1'b0;
      #1;
      checks++;
      if (ReadData1_ID !== 32'h55 || ReadData2_ID !== 32'h55) begin
         failures++;
         $display("FAIL hazard_next got=%h/%h exp=%h", ReadData1_ID, ReadData2_ID, 32'h55);
      end
      checks++;
      if (CommitCount !== 4'd4) begin
         failures++; $display("FAIL hazard_cnt got=%0d exp=%0d", CommitCount, 4);
      end
   endtask

   task automatic test_back_to_back();
      RegWrite_WB = 1'b1; MemtoReg_WB = 1'b0;
      ALUResult_WB = 32'h101; Dst_WB = 5'd1;
      tick();
      ALUResult_WB = 32'h202; Dst_WB = 5'd2;
      tick();
      RegWrite_WB = 1'b0; ReadReg1_ID = 5'd1; ReadReg2_ID = 5'd2;
      #1;
      checks++;
      if (ReadData1_ID !== 32'h101) begin
         failures++; $display("FAIL b2b_rd1 got=%h exp=%h", ReadData1_ID, 32'h101);
      end
      checks++;
      if (ReadData2_ID !== 32'h202) begin
         failures++; $display("FAIL b2b_rd2 got=%h exp=%h", ReadData2_ID, 32'h202);
      end
      checks++;
      if (CommitCount !== 4'd6) begin
         failures++; $display("FAIL b2b_cnt got=%0d exp=%0d", CommitCount, 6);
      end
   endtask

   task automatic test_saturation();
      logic [3:0] exp_cnt;
      exp_cnt = 4'd6;
      RegWrite_WB = 1'b1; MemtoReg_WB = 1'b0; Dst_WB = 5'd10;
      for (int i = 0; i < 17; i++) begin
         ALUResult_WB = 32'(i + 1);
         tick();
         if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
         checks++;
         if (CommitCount !== exp_cnt) begin
            failures++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, CommitCount, exp_cnt);
         end
      end
      // reset on the same edge as a write: write dropped, count cleared
      rst_n = 1'b0; Dst_WB = 5'd12; ALUResult_WB = 32'h77;
      tick();
      rst_n = 1'b1; RegWrite_WB = 1'b0; ReadReg1_ID = 5'd12; ReadReg2_ID = 5'd8;
      #1;
      checks++;
      if (CommitCount !== 4'd0) begin
         failures++; $display("FAIL rstwr_cnt got=%0d exp=%0d", CommitCount, 0);
      end
      checks++;
      if (ReadData1_ID !== 32'h0) begin
         failures++; $display("FAIL rstwr_reg12 got=%h exp=%h", ReadData1_ID, 32'h0);
      end
      checks++;
      if (ReadData2_ID !== 32'h0) begin
         failures++; $display("FAIL rstwr_reg8 got=%h exp=%h", ReadData2_ID, 32'h0);
      end
   endtask

   initial begin
      test_reset();
      test_alu_write();
      test_load_select();
      test_zero_guard();
      test_hazard();
      test_back_to_back();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
